cache_mem_responder: RTL
========================

# cache_mem_responder

Word-addressed backing-memory responder that answers the cache controller's memory handshake. It accepts write-back requests (`mem_write_ce`) and refill requests (`mem_read_ce`) and completes them after a fixed, parameterised latency. It signals completion with a one-cycle `mem_write_fin` / `mem_read_fin` pulse. It sits below the cache controller in place of real DRAM, for integration and system simulation.

## Interface
- `DEPTH_LOG2`, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- `READ_LATENCY`, 4: cycles from request acceptance to `mem_read_fin`; legal range ≥1.
- `WRITE_LATENCY`, 4: cycles from request acceptance to `mem_write_fin`; legal range ≥1.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_read_ce` in 1: refill request, level, held by requester until it sees `mem_read_fin`.
- `mem_write_ce` in 1: write-back request, level, held until it sees `mem_write_fin`.
- `addr` in 30: word address; only `addr[DEPTH_LOG2-1:0]` used, upper bits ignored (aliasing).
- `wdata` in 32: write-back data.
- `mem_data` out 32: read data, registered.
- `mem_read_fin` out 1: one-cycle read-complete pulse.
- `mem_write_fin` out 1: one-cycle write-complete pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
States: IDLE, WR_BUSY, RD_BUSY, RELEASE.

IDLE:
- `mem_write_ce` high: latch `addr`/`wdata`, load counter with `WRITE_LATENCY-1`, go to WR_BUSY.
- Else `mem_read_ce` high: latch `addr`, load counter with `READ_LATENCY-1`, go to RD_BUSY.
- Both high: write wins, so the dirty write-back precedes the refill.

WR_BUSY / RD_BUSY:
- Counter decrements each cycle.
- At count 0, complete the operation and go to RELEASE.
- Write completion: the array word is written with the latched data; `mem_write_fin` pulses.
- Read completion: `mem_data` is loaded with the array word at the latched address; `mem_read_fin` pulses.

RELEASE:
- Stays until the served `ce` is low, then goes to IDLE.
- A new request is sampled only in IDLE. A level-held `ce` is therefore never served twice.
- The other `ce` rising during RELEASE is accepted on the first IDLE cycle.

General rules:
- `addr`/`wdata` changes after acceptance are ignored.
- `ce` dropping during a BUSY state does not abort the operation; it completes normally.
- A read of a word written earlier returns the written value (read-after-write coherent, since the write completes before RELEASE).
- Array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset values: state IDLE, `mem_read_fin`=0, `mem_write_fin`=0, `mem_data`=0, `busy`=0, counter=0.
- Acceptance edge = the rising edge at which the state is IDLE and a `ce` is high. `busy` is high from the cycle after that edge.
- Fin pulse timing:
  - Fin is high for exactly one cycle.
  - It goes high after the edge LATENCY edges after acceptance; with LATENCY=1, fin is high in the cycle right after acceptance.
  - Fin is registered, never combinational from `ce`.
- `mem_data` updates on the same edge that raises `mem_read_fin`, and holds until the next read completion or reset.
- Array write happens on the edge that raises `mem_write_fin`.
- Minimum spacing between back-to-back requests of the same type is LATENCY+2 cycles: BUSY + RELEASE + IDLE.
- Write-back then refill (write `ce` falls and read `ce` rises on the same edge, as the controller does): RELEASE exits on that edge's following cycle, and the read is accepted one cycle later.
- Reset mid-operation:
  - State returns to IDLE immediately and all outputs take their reset values.
  - A pending write is discarded; the array is unchanged.
  - A pending read produces no fin.
- Counter width is $clog2(max(READ_LATENCY, WRITE_LATENCY)), minimum 1 bit; it never wraps because it is loaded only in IDLE.

## Test plan
- Reset mid-write: write request, assert `rst` at cycle 2 of WR_BUSY → no `mem_write_fin`; a later read of that address returns the prior contents; all outputs 0 during reset.
- Write then read, latency 4: write `addr`=0x5, `wdata`=0xDEADBEEF → `mem_write_fin` pulses exactly 4 cycles after acceptance. Then read 0x5 → `mem_read_fin` 4 cycles later with `mem_data`=0xDEADBEEF.
- Held `ce`: hold `mem_read_ce` high 10 cycles after fin → exactly one `mem_read_fin`; `busy` stays high in RELEASE until `ce` drops.
- Simultaneous `ce`: both high in IDLE, `addr`=0x3, `wdata`=0x12345678 → write served first; after write `ce` drops, the read returns 0x12345678.
- Aliasing: with DEPTH_LOG2=10, write 0xA5A5A5A5 to `addr` 0x400, read `addr` 0x000 → 0xA5A5A5A5.
- Latency 1: READ_LATENCY=WRITE_LATENCY=1 → fin in the cycle immediately after acceptance; back-to-back writes accepted every 3 cycles.

Source files
------------

// File: rtl/cache_mem_responder_if.sv
// Memory handshake between the cache controller (master) and its backing-memory responder (slave).
interface cache_mem_responder_if;
  logic        mem_read_ce;
  logic        mem_write_ce;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_data;
  logic        mem_read_fin;
  logic        mem_write_fin;
  logic        busy;

  modport master (
    output mem_read_ce, mem_write_ce, addr, wdata,
    input  mem_data, mem_read_fin, mem_write_fin, busy
  );

  modport slave (
    input  mem_read_ce, mem_write_ce, addr, wdata,
    output mem_data, mem_read_fin, mem_write_fin, busy
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-addressed backing memory that answers refill/write-back requests after a fixed latency
// with a one-cycle fin pulse; requests are sampled only in IDLE so a held ce is served once.
module cache_mem_responder #(
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_responder_if.slave  bus
);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT <= 1) ? 1 : $clog2(MAX_LAT);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RELEASE} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic                  served_wr;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem_data;
  logic                  read_fin;
  logic                  write_fin;
  logic                  busy;
  logic                  do_write;
  logic [31:0]           mem [2**DEPTH_LOG2];

  // Upper address bits alias onto the array and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[29:DEPTH_LOG2];

  assign do_write = (state == WR_BUSY) && (count == '0);

  // Array has no reset: contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (do_write) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      served_wr <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_data  <= '0;
      read_fin  <= 1'b0;
      write_fin <= 1'b0;
      busy      <= 1'b0;
    end else begin
      read_fin  <= 1'b0;
      write_fin <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_write_ce) begin
            addr_q    <= bus.addr[DEPTH_LOG2-1:0];
            wdata_q   <= bus.wdata;
            count     <= WR_LOAD;
            served_wr <= 1'b1;
            busy      <= 1'b1;
            state     <= WR_BUSY;
          end else if (bus.mem_read_ce) begin
            addr_q    <= bus.addr[DEPTH_LOG2-1:0];
            count     <= RD_LOAD;
            served_wr <= 1'b0;
            busy      <= 1'b1;
            state     <= RD_BUSY;
          end
        end
        WR_BUSY: begin
          if (count == '0) begin
            write_fin <= 1'b1;
            state     <= RELEASE;
          end else begin
            count <= count - 1'b1;
          end
        end
        RD_BUSY: begin
          if (count == '0) begin
            mem_data <= mem[addr_q];
            read_fin <= 1'b1;
            state    <= RELEASE;
          end else begin
            count <= count - 1'b1;
          end
        end
        RELEASE: begin
          if (served_wr ? !bus.mem_write_ce : !bus.mem_read_ce) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_data      = mem_data;
  assign bus.mem_read_fin  = read_fin;
  assign bus.mem_write_fin = write_fin;
  assign bus.busy          = busy;
endmodule
